// File: rtl/axi_read_arb_pkg.sv
// Shared types and requester IDs for the AXI read-channel arbiter.
package axi_read_arb_pkg;

  typedef enum logic {AR_IDLE, AR_ISSUE} ar_state_t;

  localparam logic [3:0] RID_INST = 4'd0;
  localparam logic [3:0] RID_DATA = 4'd1;

  typedef logic [31:0] axi_addr_t;
  typedef logic [31:0] axi_data_t;

endpackage

// File: rtl/axi_read_arbiter_outstanding_counter.sv
// Up/down counter of in-flight reads for one requester, with full/empty flags.
module outstanding_counter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Simultaneous grant and return cancel out.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI AR/R channel between instruction fetch and data load.
// AXI_READ_ARB_RR_EN selects round-robin arbitration; default is data-first priority.
module axi_read_arbiter
  import axi_read_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        wr_pending,
  input  logic [31:0] wr_pending_addr,
  output logic [3:0]  ar_id,
  output logic [31:0] ar_addr,
  output logic [2:0]  ar_size,
  output logic        ar_valid,
  input  logic        ar_ready,
  input  logic [3:0]  r_id,
  input  logic [31:0] r_data,
  input  logic        r_valid,
  output logic        r_ready,
  output logic        err_rid
);

  ar_state_t  state_q;
  logic       ar_valid_q;
  logic [3:0] ar_id_q;
  axi_addr_t  ar_addr_q;
  logic [2:0] ar_size_q;

  logic       inst_data_ok_q, data_data_ok_q, err_rid_q;
  axi_data_t  inst_rdata_q, data_rdata_q;

  logic       inst_full, inst_empty, data_full, data_empty;
  logic [CNT_W-1:0] inst_cnt, data_cnt;
  logic       can_grant, raw_hit, inst_elig, data_elig;
  logic       grant_inst, grant_data, inst_hit, data_hit;
  logic       unused_lsb;

  assign unused_lsb = ^{wr_pending_addr[1:0], inst_cnt, data_cnt};

  // Word-granular alias check against the store still held by the write side.
  assign raw_hit   = wr_pending && (data_addr[31:2] == wr_pending_addr[31:2]);
  assign inst_elig = inst_req && !inst_full;
  assign data_elig = data_req && !data_full && !raw_hit;
  assign can_grant = !reset && (state_q == AR_IDLE);

`ifdef AXI_READ_ARB_RR_EN
  logic rr_data_q, rr_data_d;

  always_comb begin
    rr_data_d = rr_data_q;
    if (grant_data) begin
      rr_data_d = 1'b0;
    end else if (grant_inst) begin
      rr_data_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_data_q <= 1'b1;
    end else begin
      rr_data_q <= rr_data_d;
    end
  end

  assign grant_data = can_grant && data_elig && (!inst_elig || rr_data_q);
`else
  assign grant_data = can_grant && data_elig;
`endif
  assign grant_inst = can_grant && inst_elig && !grant_data;

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= AR_IDLE;
      ar_valid_q <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_size_q  <= '0;
    end else begin
      case (state_q)
        AR_IDLE: begin
          if (grant_data || grant_inst) begin
            state_q    <= AR_ISSUE;
            ar_valid_q <= 1'b1;
            ar_id_q    <= grant_data ? RID_DATA : RID_INST;
            ar_addr_q  <= grant_data ? data_addr : inst_addr;
            ar_size_q  <= {1'b0, (grant_data ? data_size : inst_size)};
          end
        end
        AR_ISSUE: begin
          if (ar_ready) begin
            state_q    <= AR_IDLE;
            ar_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= AR_IDLE;
          ar_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // A beat only counts when its requester actually has a read in flight.
  assign inst_hit = r_valid && (r_id == RID_INST) && !inst_empty;
  assign data_hit = r_valid && (r_id == RID_DATA) && !data_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      inst_rdata_q   <= '0;
      data_rdata_q   <= '0;
      err_rid_q      <= 1'b0;
    end else begin
      inst_data_ok_q <= inst_hit;
      data_data_ok_q <= data_hit;
      if (inst_hit) begin
        inst_rdata_q <= r_data;
      end
      if (data_hit) begin
        data_rdata_q <= r_data;
      end
      if (r_valid && !inst_hit && !data_hit) begin
        err_rid_q <= 1'b1;
      end
    end
  end

  outstanding_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_inst_cnt (
    .clock  (clock),
    .reset  (reset),
    .inc_i  (grant_inst),
    .dec_i  (inst_hit),
    .count_o(inst_cnt),
    .full_o (inst_full),
    .empty_o(inst_empty)
  );

  outstanding_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_data_cnt (
    .clock  (clock),
    .reset  (reset),
    .inc_i  (grant_data),
    .dec_i  (data_hit),
    .count_o(data_cnt),
    .full_o (data_full),
    .empty_o(data_empty)
  );

  assign ar_valid     = ar_valid_q;
  assign ar_id        = ar_id_q;
  assign ar_addr      = ar_addr_q;
  assign ar_size      = ar_size_q;
  assign r_ready      = !reset;
  assign inst_data_ok = inst_data_ok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_data_ok = data_data_ok_q;
  assign data_rdata   = data_rdata_q;
  assign err_rid      = err_rid_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: transaction-level model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_axi_read_arbiter;

  localparam int MAXO = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0, data_req = 1'b0;
  logic [1:0]  inst_size = '0, data_size = '0;
  logic [31:0] inst_addr = '0, data_addr = '0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        wr_pending = 1'b0;
  logic [31:0] wr_pending_addr = '0;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [2:0]  ar_size;
  logic        ar_valid;
  logic        ar_ready = 1'b0;
  logic [3:0]  r_id = '0;
  logic [31:0] r_data = '0;
  logic        r_valid = 1'b0;
  logic        r_ready, err_rid;

  int n_chk = 0;
  int n_pass = 0;

  axi_read_arbiter #(.MAX_OUTSTANDING(MAXO), .CNT_W(3)) dut (
    .clock(clock), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_size(data_size), .data_addr(data_addr),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .wr_pending(wr_pending), .wr_pending_addr(wr_pending_addr),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_size(ar_size), .ar_valid(ar_valid),
    .ar_ready(ar_ready), .r_id(r_id), .r_data(r_data), .r_valid(r_valid),
    .r_ready(r_ready), .err_rid(err_rid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          inst_out, data_out;
  bit          busy, have_reset, m_err, e_iok, e_dok;
  bit          g_i, g_d, ie, de;
  logic [3:0]  m_id;
  logic [31:0] m_addr, e_irdata, e_drdata;
  logic [2:0]  m_size;
`ifdef AXI_READ_ARB_RR_EN
  bit          favor_data;
`endif

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        have_reset = 1; inst_out = 0; data_out = 0; busy = 0; m_err = 0;
        e_iok = 0; e_dok = 0; e_irdata = '0; e_drdata = '0;
        m_id = '0; m_addr = '0; m_size = '0;
`ifdef AXI_READ_ARB_RR_EN
        favor_data = 1;
`endif
      end else begin
        e_iok = 0; e_dok = 0;
        if (r_valid) begin
          if (r_id == 4'd0 && inst_out > 0) begin
            inst_out--; e_iok = 1; e_irdata = r_data;
          end else if (r_id == 4'd1 && data_out > 0) begin
            data_out--; e_dok = 1; e_drdata = r_data;
          end else begin
            m_err = 1;
          end
        end
        if (g_i || g_d) begin
          busy   = 1;
          m_id   = g_d ? 4'd1 : 4'd0;
          m_addr = g_d ? data_addr : inst_addr;
          m_size = {1'b0, (g_d ? data_size : inst_size)};
          if (g_d) data_out++; else inst_out++;
`ifdef AXI_READ_ARB_RR_EN
          favor_data = g_i;
`endif
        end else if (busy && ar_ready) begin
          busy = 0;
        end
      end
      @(negedge clock);
      ie = inst_req && (inst_out < MAXO);
      de = data_req && (data_out < MAXO) &&
           !(wr_pending && ((data_addr >> 2) == (wr_pending_addr >> 2)));
      g_i = 0; g_d = 0;
      if (!reset && !busy) begin
`ifdef AXI_READ_ARB_RR_EN
        if (ie && de) begin
          g_d = favor_data; g_i = !favor_data;
        end else begin
          g_d = de; g_i = ie;
        end
`else
        g_d = de; g_i = ie && !de;
`endif
      end
      if (have_reset) begin
        chk("m_r_ready", r_ready, !reset);
        chk("m_inst_addr_ok", inst_addr_ok, g_i);
        chk("m_data_addr_ok", data_addr_ok, g_d);
        chk("m_ar_valid", ar_valid, busy);
        if (busy) begin
          chk("m_ar_id", ar_id, m_id);
          chk("m_ar_addr", ar_addr, m_addr);
          chk("m_ar_size", ar_size, m_size);
        end
        chk("m_inst_data_ok", inst_data_ok, e_iok);
        chk("m_data_data_ok", data_data_ok, e_dok);
        chk("m_inst_rdata", inst_rdata, e_irdata);
        chk("m_data_rdata", data_rdata, e_drdata);
        chk("m_err_rid", err_rid, m_err);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; inst_req = 0; data_req = 0; r_valid = 0; wr_pending = 0; ar_ready = 0;
    tick(); tick();
    reset = 0;
  endtask

  int glog[$];
  int exp_order[4];

  initial begin
    // reset state
    do_reset();
    #1;
    chk("rst_r_ready", r_ready, 1'b1);
    chk("rst_ar_valid", ar_valid, 1'b0);
    chk("rst_ar_addr", ar_addr, 32'h0);
    chk("rst_err_rid", err_rid, 1'b0);
    chk("rst_inst_data_ok", inst_data_ok, 1'b0);

    // single instruction fetch
    tick();
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2; ar_ready = 1;
    #1 chk("t1_inst_addr_ok_c0", inst_addr_ok, 1'b1);
    tick();
    inst_req = 0;
    #1 chk("t1_ar_valid_c1", ar_valid, 1'b1);
    chk("t1_ar_id_c1", ar_id, 4'd0);
    chk("t1_ar_addr_c1", ar_addr, 32'hBFC0_0000);
    chk("t1_ar_size_c1", ar_size, 3'd2);
    tick();
    #1 chk("t1_ar_valid_c2", ar_valid, 1'b0);
    tick();
    r_valid = 1; r_id = 4'd0; r_data = 32'h3C08_0001;
    tick();
    r_valid = 0;
    #1 chk("t1_inst_data_ok_c4", inst_data_ok, 1'b1);
    chk("t1_inst_rdata_c4", inst_rdata, 32'h3C08_0001);

    // both requesters every cycle
    do_reset();
    inst_req = 1; data_req = 1; ar_ready = 1;
    inst_addr = 32'h0000_1000; data_addr = 32'h0000_2000; data_size = 2'd2;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (data_addr_ok) glog.push_back(1);
      if (inst_addr_ok) glog.push_back(0);
      tick();
    end
`ifdef AXI_READ_ARB_RR_EN
    exp_order = '{1, 0, 1, 0};
`else
    exp_order = '{1, 1, 0, 0};
`endif
    chk("t2_grant_count", glog.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_grant%0d", k), (k < glog.size()) ? glog[k] : -1, exp_order[k]);
    end

    // RAW hazard blocks data
    do_reset();
    wr_pending = 1; wr_pending_addr = 32'h8000_1004; ar_ready = 1;
    data_req = 1; data_addr = 32'h8000_1006; inst_req = 1; inst_addr = 32'h8000_0000;
    #1 chk("t3_data_blocked_c0", data_addr_ok, 1'b0);
    chk("t3_inst_granted_c0", inst_addr_ok, 1'b1);
    tick();
    inst_req = 0;
    tick();
    #1 chk("t3_data_blocked_c2", data_addr_ok, 1'b0);
    wr_pending = 0;
    #1 chk("t3_data_granted_c2", data_addr_ok, 1'b1);
    tick();
    data_req = 0;
    tick();

    // AR stall for 5 cycles
    do_reset();
    data_req = 1; data_addr = 32'h1234_5678; data_size = 2'd2;
    tick();
    inst_req = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_ar_valid", ar_valid, 1'b1);
      chk("t4_ar_addr", ar_addr, 32'h1234_5678);
      chk("t4_ar_id", ar_id, 4'd1);
      chk("t4_no_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
      tick();
    end
    ar_ready = 1;
    tick();
    inst_req = 0; data_req = 0;
    tick();

    // interleaved returns
    do_reset();
    ar_ready = 1; data_req = 1; data_addr = 32'h0000_3000;
    tick(); tick(); tick();
    data_req = 0; inst_req = 1;
    tick();
    tick();
    inst_req = 0;
    tick();
    r_valid = 1; r_id = 4'd1; r_data = 32'h11;
    tick();
    r_id = 4'd0; r_data = 32'h22;
    #1 chk("t5_data_ok_0x11", data_data_ok, 1'b1);
    chk("t5_data_rdata_0x11", data_rdata, 32'h11);
    tick();
    r_id = 4'd1; r_data = 32'h33;
    #1 chk("t5_inst_rdata_0x22", inst_rdata, 32'h22);
    chk("t5_data_ok_gap", data_data_ok, 1'b0);
    tick();
    r_valid = 0;
    #1 chk("t5_data_rdata_0x33", data_rdata, 32'h33);
    chk("t5_inst_rdata_hold", inst_rdata, 32'h22);
    tick();
    r_valid = 1; r_id = 4'd1; r_data = 32'h44;
    tick();
    r_valid = 0;
    #1 chk("t5_zero_cnt_err", err_rid, 1'b1);
    chk("t5_zero_cnt_no_ok", data_data_ok, 1'b0);
    chk("t5_zero_cnt_hold", data_rdata, 32'h33);

    // unknown RID
    do_reset();
    #1 chk("t6_err_cleared", err_rid, 1'b0);
    ar_ready = 1; inst_req = 1; inst_addr = 32'h0000_0040;
    tick();
    inst_req = 0;
    tick();
    r_valid = 1; r_id = 4'd5; r_data = 32'hDEAD_BEEF;
    tick();
    r_id = 4'd0; r_data = 32'h55; inst_req = 1;
    #1 chk("t6_err_set", err_rid, 1'b1);
    chk("t6_no_ok", {inst_data_ok, data_data_ok}, 2'b00);
    tick();
    r_valid = 0; inst_req = 0;
    #1 chk("t6_inst_ok_after_bad", inst_data_ok, 1'b1);
    chk("t6_inst_rdata", inst_rdata, 32'h55);
    tick(); tick();
    r_valid = 1; r_id = 4'd0; r_data = 32'h66;
    tick();
    r_valid = 0;
    #1 chk("t6_same_cycle_cnt", inst_data_ok, 1'b1);
    chk("t6_inst_rdata2", inst_rdata, 32'h66);
    tick(); tick();
    chk("t6_err_sticky", err_rid, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
